// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared FM voice types, default widths and wavetable_lerp states
package fm_pkg;

  localparam int FM_AW = 12;
  localparam int FM_IW = 20;
  localparam int FM_SW = 16;
  localparam int FM_FW = 10;

  typedef logic signed [FM_SW-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR1 = 3'd1,
    ST_CAP0  = 3'd2,
    ST_CAP1  = 3'd3,
    ST_MUL   = 3'd4
  } wt_state_t;

endpackage

// File: rtl/wt_lerp_calc.sv
// rtl/wt_lerp_calc.sv - combinational linear interpolation s0 + ((s1-s0)*f >>> FW)
// The result always lies between s0 and s1, so truncation to SW bits is lossless.
module wt_lerp_calc #(
  parameter int SW = 16,
  parameter int FW = 10
) (
  input  logic signed [SW-1:0] i_s0,
  input  logic signed [SW-1:0] i_s1,
  input  logic        [FW-1:0] i_f,
  output logic signed [SW-1:0] o_result
);

  logic signed [SW:0]      w_diff;
  logic signed [SW+FW+1:0] w_prod;

  assign w_diff   = {i_s1[SW-1], i_s1} - {i_s0[SW-1], i_s0};
  assign w_prod   = w_diff * $signed({1'b0, i_f});
  assign o_result = i_s0 + SW'(w_prod >>> FW);

endmodule

// File: rtl/wavetable_lerp.sv
// rtl/wavetable_lerp.sv - wavetable ROM reader with linear interpolation
// WT_INTERP_EN defined: two reads and interpolation, latency 5.
// WT_INTERP_EN undefined: single nearest-sample read, latency 3, frac ignored.
module wavetable_lerp
  import fm_pkg::*;
#(
  parameter int AW = FM_AW,
  parameter int IW = FM_IW,
  parameter int SW = FM_SW,
  parameter int FW = FM_FW
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic        [AW-1:0] addr,
  input  logic        [IW-1:0] frac,
  output logic                 rom_en,
  output logic        [AW-1:0] rom_addr,
  input  logic signed [SW-1:0] rom_data,
  output logic                 out_valid,
  output logic signed [SW-1:0] out_sample
);

  wt_state_t r_state, w_state_nxt;

  logic                 r_rom_en, w_rom_en_nxt;
  logic        [AW-1:0] r_rom_addr, w_rom_addr_nxt;
  logic                 r_out_valid, w_out_valid_nxt;
  logic signed [SW-1:0] r_out_sample, w_out_sample_nxt;
  logic signed [SW-1:0] w_result;
  logic                 w_unused_frac;

  // low fraction bits (and all of frac in nearest mode) intentionally dropped
  assign w_unused_frac = ^frac;

`ifdef WT_INTERP_EN
  logic        [AW-1:0] r_a, w_a_nxt;
  logic        [FW-1:0] r_f, w_f_nxt;
  logic signed [SW-1:0] r_s0, w_s0_nxt;
  logic signed [SW-1:0] r_s1, w_s1_nxt;

  wt_lerp_calc #(.SW(SW), .FW(FW)) u_calc (
    .i_s0     (r_s0),
    .i_s1     (r_s1),
    .i_f      (r_f),
    .o_result (w_result)
  );
`else
  // zero fraction makes the datapath pass rom_data through unchanged
  wt_lerp_calc #(.SW(SW), .FW(FW)) u_calc (
    .i_s0     (rom_data),
    .i_s1     (rom_data),
    .i_f      ({FW{1'b0}}),
    .o_result (w_result)
  );
`endif

  assign in_ready   = (r_state == ST_IDLE) && !Reset;
  assign rom_en     = r_rom_en;
  assign rom_addr   = r_rom_addr;
  assign out_valid  = r_out_valid;
  assign out_sample = r_out_sample;

  // next-state and next-register values for the read/interpolate sequence
  always_comb begin
    w_state_nxt      = r_state;
    w_rom_en_nxt     = 1'b0;
    w_rom_addr_nxt   = r_rom_addr;
    w_out_valid_nxt  = 1'b0;
    w_out_sample_nxt = r_out_sample;
`ifdef WT_INTERP_EN
    w_a_nxt  = r_a;
    w_f_nxt  = r_f;
    w_s0_nxt = r_s0;
    w_s1_nxt = r_s1;
`endif
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_rom_addr_nxt = addr;
          w_rom_en_nxt   = 1'b1;
          w_state_nxt    = ST_ADDR1;
`ifdef WT_INTERP_EN
          w_a_nxt = addr;
          w_f_nxt = frac[IW-1 -: FW];
`endif
        end
      end
      ST_ADDR1: begin
`ifdef WT_INTERP_EN
        w_rom_addr_nxt = r_a + AW'(1);
        w_rom_en_nxt   = 1'b1;
`endif
        w_state_nxt = ST_CAP0;
      end
      ST_CAP0: begin
`ifdef WT_INTERP_EN
        w_s0_nxt    = rom_data;
        w_state_nxt = ST_CAP1;
`else
        w_out_sample_nxt = w_result;
        w_out_valid_nxt  = 1'b1;
        w_state_nxt      = ST_IDLE;
`endif
      end
`ifdef WT_INTERP_EN
      ST_CAP1: begin
        w_s1_nxt    = rom_data;
        w_state_nxt = ST_MUL;
      end
      ST_MUL: begin
        w_out_sample_nxt = w_result;
        w_out_valid_nxt  = 1'b1;
        w_state_nxt      = ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state and output registers; reset discards any in-flight request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_rom_en     <= 1'b0;
      r_rom_addr   <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rom_en     <= w_rom_en_nxt;
      r_rom_addr   <= w_rom_addr_nxt;
      r_out_valid  <= w_out_valid_nxt;
      r_out_sample <= w_out_sample_nxt;
    end
  end

`ifdef WT_INTERP_EN
  // request operands and captured samples
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_a  <= '0;
      r_f  <= '0;
      r_s0 <= '0;
      r_s1 <= '0;
    end else begin
      r_a  <= w_a_nxt;
      r_f  <= w_f_nxt;
      r_s0 <= w_s0_nxt;
      r_s1 <= w_s1_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_wavetable_lerp.sv
// tb/tb_wavetable_lerp.sv - self-checking bench for wavetable_lerp
module tb_wavetable_lerp;

`ifdef WT_INTERP_EN
  localparam int LAT = 5;
  localparam int NREAD = 2;
`else
  localparam int LAT = 3;
  localparam int NREAD = 1;
`endif

  logic               Clk = 1'b0;
  logic               Reset;
  logic               in_valid;
  logic               in_ready;
  logic        [11:0] addr;
  logic        [19:0] frac;
  logic               rom_en;
  logic        [11:0] rom_addr;
  logic signed [15:0] rom_data;
  logic               out_valid;
  logic signed [15:0] out_sample;

  logic signed [15:0] mem [4096];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wavetable_lerp dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .addr       (addr),
    .frac       (frac),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_sample (out_sample)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (rom_en) rom_data <= mem[rom_addr];
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: sample at a, plus the floored fraction of the step to the next entry
  function automatic int model(input int a, input int f);
    int s0, s1, p, q;
    s0 = int'(mem[a % 4096]);
    s1 = int'(mem[(a + 1) % 4096]);
`ifdef WT_INTERP_EN
    p = (s1 - s0) * f;
    if (p >= 0) q = p / 1024;
    else q = -((-p + 1023) / 1024);
    return s0 + q;
`else
    s1 = s1 + p * 0;
    q = f * 0;
    return s0 + q;
`endif
  endfunction

  task automatic do_req(input int a, input logic [19:0] fr, input string tag);
    int exp, lat_seen, npulse, w;
    int raddr[$];
    exp = model(a, int'(fr[19:10]));
    w = 0;
    @(negedge Clk);
    while (!in_ready && w < 20) begin
      @(negedge Clk);
      w++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    addr = 12'(a);
    frac = fr;
    lat_seen = -1;
    npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clk);
      in_valid = 1'b0;
      if (k == 1) chk({tag, "_busy"}, in_ready, 0);
      if (rom_en) raddr.push_back(int'(rom_addr));
      if (out_valid) begin
        npulse++;
        if (lat_seen < 0) begin
          lat_seen = k;
          chk({tag, "_value"}, out_sample, exp);
          chk({tag, "_ready_at_out"}, in_ready, 1);
        end
      end
    end
    chk({tag, "_latency"}, lat_seen, LAT);
    chk({tag, "_pulses"}, npulse, 1);
    chk({tag, "_nread"}, raddr.size(), NREAD);
    if (raddr.size() >= 1) chk({tag, "_raddr0"}, raddr[0], a);
    if (raddr.size() >= 2) chk({tag, "_raddr1"}, raddr[1], (a + 1) % 4096);
  endtask

  int ba[3];
  int bf[3];
  int bexp[$];
  int bacc[$];
  int bobs[$];
  int bocyc[$];
  int idx;
  int rnd_a;
  logic [19:0] rnd_f;

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0;
    addr = '0;
    frac = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 64);

    @(negedge Clk);
    chk("reset_in_ready", in_ready, 0);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_rom_en", rom_en, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_sample", out_sample, 0);
    chk("reset_in_ready_after", in_ready, 1);

    do_req(10, 20'(512 << 10), "basic");

    mem[4095] = 16'sd1000;
    mem[0] = -16'sd1000;
    do_req(4095, 20'(256 << 10), "wrap");

    do_req(37, 20'h003ff, "f_zero");
    mem[100] = -16'sd32768;
    mem[101] = 16'sd32767;
    do_req(100, 20'(1023 << 10) | 20'h3ff, "f_max");

    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 12; n++) begin
      rnd_a = int'($urandom_range(0, 4095));
      rnd_f = 20'($urandom);
      do_req(rnd_a, rnd_f, "random");
    end
    do_req(4095, 20'($urandom), "random_wrap");

    ba[0] = 5;    bf[0] = int'(20'($urandom));
    ba[1] = 4095; bf[1] = int'(20'($urandom));
    ba[2] = 2000; bf[2] = int'(20'($urandom));
    idx = 0;
    @(negedge Clk);
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        bobs.push_back(int'(out_sample));
        bocyc.push_back(cyc);
      end
      if (in_ready && idx < 3) begin
        addr = 12'(ba[idx]);
        frac = 20'(bf[idx]);
        in_valid = 1'b1;
        bacc.push_back(cyc);
        bexp.push_back(model(ba[idx], bf[idx] >> 10));
        idx++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end
      @(negedge Clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", bacc.size(), 3);
    chk("b2b_outputs", bobs.size(), 3);
    if (bacc.size() == 3 && bobs.size() == 3) begin
      chk("b2b_spacing1", bacc[1] - bacc[0], LAT);
      chk("b2b_spacing2", bacc[2] - bacc[1], LAT);
      for (int i = 0; i < 3; i++) begin
        chk("b2b_out_cycle", bocyc[i] - bacc[i], LAT);
        chk("b2b_value", bobs[i], bexp[i]);
      end
    end

    @(negedge Clk);
    addr = 12'd77;
    frac = 20'hfffff;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midreset_in_ready_low", in_ready, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("midreset_rom_en", rom_en, 0);
    chk("midreset_out_sample", out_sample, 0);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 1);
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (out_valid) idx++;
    end
    chk("midreset_no_output", idx, 0);

    do_req(77, 20'h80000, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
